// File: rtl/uart_dut.sv
// UART echo block: receives 8N1 bytes, echoes them on tx_o, shows the last two bytes on a 4-digit 7-segment display.
// Latency: the echo start bit begins 2 cycles after the internal rx_valid pulse when the transmitter is idle.
// Backpressure: one-byte holding buffer; a byte arriving while the buffer is still full is dropped (display still updates).
module uart_dut #(
  parameter int CLKS_PER_BIT = 434,
  parameter int REFRESH_DIV  = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [3:0] anodos_o,
  output logic [7:0] segmentos_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [BW-1:0] BIT_M1  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [RW-1:0] REF_M1  = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  // Two-flop synchronizer; flops reset to the idle (high) line level
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------
  rx_state_t       rx_state;
  logic [BW-1:0]   rx_cnt;
  logic [2:0]      rx_idx;
  logic [7:0]      rx_shift;
  logic            rx_ferr;
  logic            rx_valid;
  logic [7:0]      rx_byte;

  // Receive FSM: half-bit start qualification, mid-bit data sampling, stop check
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_ferr  <= 1'b0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt  <= '0;
          rx_idx  <= '0;
          rx_ferr <= 1'b0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            // a line that is high again at mid start bit was only a glitch
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_M1) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_ferr) begin
            // framing error: hold off until the line is idle again
            if (rx_sync) begin
              rx_ferr  <= 1'b0;
              rx_state <= RX_IDLE;
            end
          end else if (rx_cnt == BIT_M1) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
              rx_state <= RX_IDLE;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Display register
  // ---------------------------------------------------------------
  logic [15:0] disp;

  // Shift each received byte into the low half of the display
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) disp <= '0;
    else if (rx_valid) disp <= {disp[7:0], rx_byte};
  end

  // ---------------------------------------------------------------
  // Holding buffer and transmitter
  // ---------------------------------------------------------------
  tx_state_t       tx_state;
  logic [BW-1:0]   tx_cnt;
  logic [2:0]      tx_idx;
  logic [7:0]      tx_shift;
  logic            buf_full;
  logic [7:0]      buf_dat;

  // Buffer load/free and transmit FSM share one block so the buffer has a single driver
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_full <= 1'b0;
      buf_dat  <= '0;
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_o     <= 1'b1;
    end else begin
      // a byte arriving while the buffer is occupied is dropped
      if (rx_valid && !buf_full) begin
        buf_dat  <= rx_byte;
        buf_full <= 1'b1;
      end
      case (tx_state)
        TX_IDLE: begin
          tx_o   <= 1'b1;
          tx_cnt <= '0;
          tx_idx <= '0;
          if (buf_full) begin
            tx_shift <= buf_dat;
            buf_full <= 1'b0;
            tx_o     <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_M1) begin
            tx_cnt   <= '0;
            tx_o     <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_M1) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              tx_o     <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_o     <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_M1) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------
  logic [RW-1:0] scan_cnt;
  logic [1:0]    digit;
  logic [1:0]    digit_nxt;
  logic [3:0]    nibble;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Digit to show after this edge, and its nibble from the display register
  always_comb begin
    digit_nxt = (scan_cnt == REF_M1) ? digit + 2'd1 : digit;
    case (digit_nxt)
      2'd0:    nibble = disp[3:0];
      2'd1:    nibble = disp[7:4];
      2'd2:    nibble = disp[11:8];
      default: nibble = disp[15:12];
    endcase
  end

  // Registered anode and segment drive, both derived from the same digit so they switch together
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scan_cnt    <= '0;
      digit       <= '0;
      anodos_o    <= 4'b1110;
      segmentos_o <= 8'hC0;
    end else begin
      scan_cnt    <= (scan_cnt == REF_M1) ? '0 : scan_cnt + 1'b1;
      digit       <= digit_nxt;
      anodos_o    <= ~(4'b0001 << digit_nxt);
      segmentos_o <= hex7(nibble);
    end
  end

endmodule

// File: tb/tb_uart_dut.sv
// Bench for uart_dut: directed frames on rx_i, a behavioural model of echo timing and display,
// a per-cycle compare process, a serial decoder on tx_o, and literal spot checks.
module tb_uart_dut;

  localparam int CPB   = 16;
  localparam int RD    = 4;
  localparam int HALF  = CPB / 2;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       tx_o;
  logic [3:0] anodos;
  logic [7:0] segs;

  always #5 clk = ~clk;

  uart_dut #(.CLKS_PER_BIT(CPB), .REFRESH_DIV(RD)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i),
    .tx_o(tx_o), .anodos_o(anodos), .segmentos_o(segs)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  // ---------------- model ----------------
  int         ev_s[$];        // cycle of the mid-stop sample of each valid frame
  logic [7:0] ev_b[$];
  int         fr_t[$];        // first cycle tx_o is low for each expected echo
  logic [7:0] fr_b[$];
  int         t_prev = -100000;
  int         k = 0;          // edges since reset release
  int         last_change = -10;
  int         t_new;
  logic [15:0] mdisp = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_i) begin
      k = 0; mdisp = '0; t_prev = -100000;
      ev_s.delete(); ev_b.delete(); fr_t.delete(); fr_b.delete();
    end else begin
      k++;
      if (ev_s.size() > 0 && ev_s[0] + 1 == cyc) begin
        mdisp = {mdisp[7:0], ev_b[0]};
        last_change = cyc;
        // buffer is free only if the previous accepted byte was taken by the sample cycle
        if (t_prev <= ev_s[0]) begin
          t_new = (ev_s[0] + 2 > t_prev + FRAME + 1) ? ev_s[0] + 2 : t_prev + FRAME + 1;
          fr_t.push_back(t_new); fr_b.push_back(ev_b[0]);
          t_prev = t_new;
        end
        void'(ev_s.pop_front()); void'(ev_b.pop_front());
      end
      while (fr_t.size() > 0 && fr_t[0] + FRAME < cyc) begin
        void'(fr_t.pop_front()); void'(fr_b.pop_front());
      end
    end
  end

  function automatic logic exp_tx(input int e);
    int idx;
    foreach (fr_t[i]) begin
      if (e >= fr_t[i] && e < fr_t[i] + FRAME) begin
        idx = (e - fr_t[i]) / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return fr_b[i][idx-1];
      end
    end
    return 1'b1;
  endfunction

  // ---------------- per-cycle compare ----------------
  int         d;
  logic [3:0] exp_an;
  always @(negedge clk) begin
    if (started) begin
      if (!rst_i) begin
        check("rst_tx", tx_o, 1);
        check("rst_anodos", anodos, 4'hE);
        check("rst_segs", segs, 8'hC0);
      end else begin
        d = (k / RD) % 4;
        exp_an = ~(4'b0001 << d);
        check("scan_anodos", anodos, exp_an);
        if (cyc - last_change > 1) check("scan_segs", segs, hex7(mdisp[d*4 +: 4]));
        check("tx_line", tx_o, exp_tx(cyc));
      end
    end
  end

  // ---------------- serial decoder on tx_o ----------------
  logic [7:0] dec_b[$];
  int         dec_t[$];
  logic       prev_tx = 1'b1;
  logic [7:0] db;
  int         dst;
  bit         dok;
  always begin
    @(negedge clk);
    if (started && rst_i && prev_tx && !tx_o) begin
      dst = cyc; dok = 1'b1; db = '0;
      for (int j = 0; j < HALF; j++) begin @(negedge clk); if (!rst_i) dok = 1'b0; end
      if (tx_o !== 1'b0) dok = 1'b0;
      for (int b = 0; b < 8; b++) begin
        for (int j = 0; j < CPB; j++) begin @(negedge clk); if (!rst_i) dok = 1'b0; end
        db[b] = tx_o;
      end
      for (int j = 0; j < CPB; j++) begin @(negedge clk); if (!rst_i) dok = 1'b0; end
      if (tx_o !== 1'b1) dok = 1'b0;
      if (dok) begin dec_b.push_back(db); dec_t.push_back(dst); end
    end
    prev_tx = tx_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic align();
    @(posedge clk); #1;
  endtask

  // Caller is 1 time unit after a posedge; n is the first edge that samples the start bit
  task automatic send(input logic [7:0] b, input logic stop, output int n);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    n = cyc + 1;
    if (stop) begin
      ev_s.push_back(n + 2 + HALF + 9 * CPB);
      ev_b.push_back(b);
    end
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_dec(input int n, input int budget);
    int c = 0;
    while (dec_b.size() < n && c < budget) begin @(negedge clk); c++; end
    check("echo_count", dec_b.size(), n);
  endtask

  task automatic seg_at(input string name, input logic [3:0] an, input logic [7:0] exp);
    int c = 0;
    @(negedge clk);
    while (anodos !== an && c < 40) begin @(negedge clk); c++; end
    check(name, segs, exp);
  endtask

  function automatic logic [7:0] dec_at(input int i);
    if (i < dec_b.size()) return dec_b[i];
    return 8'hxx;
  endfunction

  function automatic int dec_time(input int i);
    if (i < dec_t.size()) return dec_t[i];
    return -1;
  endfunction

  // ---------------- main sequence ----------------
  logic [3:0] an_seq [4] = '{4'hD, 4'hB, 4'h7, 4'hE};
  int n, n2;

  initial begin
    #1 rst_i = 1'b0;
    started = 1'b1;
    #2;
    check("s1_rst_tx", tx_o, 1);
    check("s1_rst_anodos", anodos, 4'hE);
    check("s1_rst_segs", segs, 8'hC0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_i = 1'b1;

    // 1: scan sequence after release
    for (int j = 0; j < 4; j++) begin
      repeat (RD) @(posedge clk);
      @(negedge clk);
      check("s1_anodos_seq", anodos, an_seq[j]);
      check("s1_segs_zero", segs, 8'hC0);
    end

    // 2: single byte 0x41
    align();
    send(8'h41, 1'b1, n);
    wait_dec(1, 400);
    check("s2_echo_byte", dec_at(0), 8'h41);
    check("s2_echo_latency", dec_time(0) - n, 156);
    check("s2_model_disp", mdisp, 16'h0041);
    seg_at("s2_digit0", 4'hE, 8'hF9);
    seg_at("s2_digit1", 4'hD, 8'h99);
    seg_at("s2_digit2", 4'hB, 8'hC0);

    // 3: back-to-back 0xA5, 0x3C
    repeat (40) @(posedge clk);
    align();
    send(8'hA5, 1'b1, n);
    send(8'h3C, 1'b1, n2);
    check("s3_back_to_back", n2 - n, FRAME);
    wait_dec(3, 800);
    check("s3_echo_first", dec_at(1), 8'hA5);
    check("s3_echo_second", dec_at(2), 8'h3C);
    check("s3_first_latency", dec_time(1) - n, 156);
    seg_at("s3_digit3", 4'h7, 8'h88);
    seg_at("s3_digit2", 4'hB, 8'h92);
    seg_at("s3_digit1", 4'hD, 8'hB0);
    seg_at("s3_digit0", 4'hE, 8'hC6);

    // 4: short glitch
    repeat (40) @(posedge clk);
    align();
    rx_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (200) @(posedge clk);
    check("s4_no_echo", dec_b.size(), 3);
    check("s4_model_disp", mdisp, 16'hA53C);

    // 5: framing error then valid 0x12
    align();
    send(8'h55, 1'b0, n);
    repeat (10) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (200) @(posedge clk);
    check("s5_no_echo", dec_b.size(), 3);
    align();
    send(8'h12, 1'b1, n);
    wait_dec(4, 400);
    check("s5_echo_byte", dec_at(3), 8'h12);
    check("s5_echo_latency", dec_time(3) - n, 156);
    check("s5_model_disp", mdisp, 16'h3C12);
    seg_at("s5_digit0", 4'hE, 8'hA4);
    seg_at("s5_digit1", 4'hD, 8'hF9);
    seg_at("s5_digit2", 4'hB, 8'hC6);
    seg_at("s5_digit3", 4'h7, 8'hB0);

    // 6: reset during the echo of 0xFF
    repeat (40) @(posedge clk);
    align();
    send(8'hFF, 1'b1, n);
    while (cyc < n + 160) @(posedge clk);
    #2;
    check("s6_tx_in_start_bit", tx_o, 0);
    rst_i = 1'b0;
    #1;
    check("s6_tx_on_reset", tx_o, 1);
    check("s6_anodos_on_reset", anodos, 4'hE);
    check("s6_segs_on_reset", segs, 8'hC0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_i = 1'b1;
    check("s6_model_disp", mdisp, 16'h0000);
    repeat (200) @(posedge clk);
    check("s6_aborted_not_echoed", dec_b.size(), 4);
    align();
    send(8'h7E, 1'b1, n);
    wait_dec(5, 400);
    check("s6_echo_byte", dec_at(4), 8'h7E);
    check("s6_echo_latency", dec_time(4) - n, 156);
    seg_at("s6_digit0", 4'hE, 8'h86);
    seg_at("s6_digit1", 4'hD, 8'hF8);
    seg_at("s6_digit2", 4'hB, 8'hC0);
    repeat (200) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, expected completion before time 500000");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
